z88_ps2_kbd: RTL and testbench
==============================

Name: z88_ps2_kbd

Overview:
PS/2 keyboard front end that generates the 64-key Z88 keyboard matrix and the flap switch, which the Blink consumes on kb_matrix and flap_sw. It receives PS/2 device-to-host frames, decodes make, break and extended (E0) sequences, and maps each scancode to a matrix bit. It runs on the 50 MHz clk, with all sampling qualified by clk_ena (12.5 MHz).

Parameters:
FILT_LEN, 8, number of consecutive clk_ena samples for which ps2_clk must be stable before a level change is accepted
TIMEOUT, 25000, clk_ena ticks (2 ms) allowed between accepted ps2_clk falling edges before the frame is aborted

Ports:
clk  in  1  master clock, 50 MHz
rst  in  1  reset
clk_ena  in  1  12.5 MHz sample enable
ps2_clk  in  1  PS/2 clock from pad, asynchronous
ps2_dat  in  1  PS/2 data from pad, asynchronous
kb_matrix  out  64  1 = key down; bit index = col*8 + row; col n is read when address line A(8+n) is low
flap_sw  out  1  1 = flap open
scan_code  out  8  last good received byte (debug)
scan_vld  out  1  one-clk strobe when scan_code updates
frame_err  out  1  one-clk strobe on a parity, start, stop or timeout error

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - Reset values: kb_matrix = 0, flap_sw = 0, scan_code = 0x00, scan_vld = 0, frame_err = 0.
  - All FSMs return to IDLE and all prefix flags clear, including when rst asserts mid-frame.
- Input synchronisation: ps2_clk and ps2_dat each pass through a 2-flop synchroniser clocked every clk.
- Clock filter, updated on clk_ena:
  - The filtered clock changes only after the synchronised ps2_clk has differed from it for FILT_LEN consecutive clk_ena ticks.
  - A falling edge of the filtered clock samples the synchronised ps2_dat.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP.
  - IDLE: a sampled 0 (start bit) moves to DATA. A sampled 1 stays in IDLE with no error.
  - DATA: 8 bits, LSB first, bit counter 0..7. After bit 7, go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: the frame is good when the stop bit is 1 and the XOR of the 8 data bits and parity is 1 (odd parity).
    - Good frame: load scan_code, pulse scan_vld on the next clk.
    - Bad frame: pulse frame_err instead.
    - Either way, return to IDLE.
  - Timeout: a watchdog counts clk_ena ticks outside IDLE and reloads on each accepted falling edge. Reaching TIMEOUT forces IDLE and pulses frame_err. Any partial byte is discarded.
- Decode FSM, acting on each scan_vld byte in order:
  - 0xE0: set ext.
  - 0xF0: set brk.
  - 0xE1: load skip counter = 7. The next 7 bytes are ignored, decrementing the counter, and flags are unchanged. Pause makes no matrix change.
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF: ignored; ext and brk cleared.
  - 0x07 (F12) with ext = 0: on make, flap_sw toggles; on break, no change. Flags cleared. The matrix is untouched.
  - Any other byte: look up {ext, byte}.
    - Valid entry: kb_matrix[index] <= ~brk.
    - Invalid entry: no change.
    - Flags cleared in both cases.
  - Typematic repeats (repeated makes) are idempotent.
- Latency: kb_matrix and flap_sw update exactly 1 clk after scan_vld, i.e. 2 clk after the stop-bit sampling edge.
- Error handling:
  - frame_err does not modify the matrix or the flags.
  - A stuck key is possible only if its break frame is lost. This is accepted; no auto-release.
- Keymap entries fixed by this spec (the full table is in the package):
  - 0x1C (A) -> 49
  - 0x12 (LShift) -> 62
  - 0x59 (RShift) -> 63
  - 0x5A (Enter) -> 6
  - 0x29 (Space) -> 37
  - E0 0x75 (Up) -> 38
  - E0 0x72 (Down) -> 39
  - 0x75 (keypad 8, no E0) -> invalid

Decomposition:
- Package z88_kbd_pkg holds:
  - PS/2 special byte constants (E0, F0, E1, AA, FA, EE, FE).
  - Frame FSM and decode FSM state encodings.
  - The keymap constant array: 512 entries indexed by {ext, code}, each {valid, index[5:0]}.
- Sub-module z88_ps2_rx: synchroniser, filter, frame FSM and timeout. Outputs are byte, byte_vld and frame_err.
- The top level holds the decode FSM, the matrix register and flap_sw.

Test Plan:
- Send 0x1C, then F0 1C -> kb_matrix[49] = 1 two clk after the first stop bit, then returns to 0. scan_code sequence: 1C, F0, 1C.
- Send E0 75 -> only bit 38 set. Then send plain 75 -> no change. Then E0 F0 75 -> bit 38 clears and kb_matrix = 0.
- Send 0x1C with bad parity -> one frame_err pulse, no scan_vld, matrix unchanged. Then a good 0x12 -> bit 62 set.
- Send a start bit and 4 data bits, then hold ps2_clk high for more than 25000 clk_ena ticks -> frame_err pulse. A following full 0x29 frame sets bit 37.
- Send 0x07 twice, then F0 07 -> flap_sw goes 0 -> 1 -> 0 and stays 0. Send E1 14 77 E1 F0 14 F0 77 -> no matrix change. A following 0x5A sets bit 6.
- Add a 3-clk_ena glitch on ps2_clk mid-frame, then assert rst mid-frame -> the glitch is rejected and the byte is still received correctly. On rst, all outputs return to reset values and the next full frame decodes normally.

Source files
------------

// File: rtl/z88_kbd_pkg.sv
// rtl/z88_kbd_pkg.sv - PS/2 byte constants, FSM encodings and scancode-to-Z88-matrix keymap
package z88_kbd_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;
    localparam logic [7:0] PS2_F12    = 8'h07;

    // Pause/Break sends E1 followed by seven more bytes that carry no key meaning.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {FR_IDLE, FR_DATA, FR_PARITY, FR_STOP} frame_state_t;
    typedef enum logic {DEC_KEY, DEC_SKIP} dec_state_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;    // col*8 + row
    } key_ent_t;

    function automatic key_ent_t hit(input int unsigned i);
        return '{valid: 1'b1, idx: 6'(i)};
    endfunction

    // 512-entry keymap indexed by {ext, code}; unlisted codes are invalid.
    function automatic key_ent_t key_lookup(input logic [8:0] key);
        key_ent_t e;
        e = '{valid: 1'b0, idx: 6'd0};
        case (key)
            9'h01C: e = hit(49);    // A
            9'h012: e = hit(62);    // left shift
            9'h059: e = hit(63);    // right shift
            9'h05A: e = hit(6);     // enter
            9'h15A: e = hit(6);     // keypad enter
            9'h029: e = hit(37);    // space
            9'h175: e = hit(38);    // up
            9'h172: e = hit(39);    // down
            9'h16B: e = hit(35);    // left
            9'h174: e = hit(36);    // right
            9'h076: e = hit(61);    // esc
            9'h00D: e = hit(53);    // tab
            9'h066: e = hit(7);     // backspace -> del
            9'h015: e = hit(41);    // Q
            9'h016: e = hit(45);    // 1
            9'h058: e = hit(59);    // caps lock
            9'h014: e = hit(52);    // left ctrl -> diamond
            9'h011: e = hit(54);    // left alt -> square
            default: e = '{valid: 1'b0, idx: 6'd0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/z88_ps2_rx.sv
// rtl/z88_ps2_rx.sv - PS/2 receiver: synchroniser, clock filter, frame FSM, watchdog
// Ports: clk, rst (async, active-high), clk_ena sample enable, ps2_clk/ps2_dat pads;
//        rx_byte last good byte, rx_vld one-clk strobe, rx_err one-clk error strobe.
module z88_ps2_rx
    import z88_kbd_pkg::*;
#(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_ena,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       rx_err
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          filt;
    logic [FW-1:0] filt_cnt;
    logic          filt_flip, fall;

    frame_state_t  state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n, byte_n;
    logic          par, par_n, vld_n, err_n;
    logic [TW-1:0] wdog, wdog_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // The filtered clock flips on the FILT_LEN-th consecutive differing tick.
    assign filt_flip = clk_ena && (clk_s != filt) && (filt_cnt == FW'(FILT_LEN - 1));
    assign fall      = filt_flip && filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt     <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_ena) begin
            if (clk_s == filt) begin
                filt_cnt <= '0;
            end else if (filt_flip) begin
                filt     <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FR_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            wdog    <= '0;
            rx_byte <= '0;
            rx_vld  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par     <= par_n;
            wdog    <= wdog_n;
            rx_byte <= byte_n;
            rx_vld  <= vld_n;
            rx_err  <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par;
        byte_n    = rx_byte;
        vld_n     = 1'b0;
        err_n     = 1'b0;

        if (fall || state == FR_IDLE)
            wdog_n = '0;
        else if (clk_ena)
            wdog_n = wdog + TW'(1);
        else
            wdog_n = wdog;

        if (state != FR_IDLE && clk_ena && !fall && wdog == TW'(TIMEOUT - 1)) begin
            state_n = FR_IDLE;
            err_n   = 1'b1;
            wdog_n  = '0;
        end else if (fall) begin
            case (state)
                FR_IDLE: begin
                    bit_cnt_n = '0;
                    if (!dat_s)
                        state_n = FR_DATA;
                end
                FR_DATA: begin
                    shreg_n   = {dat_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = FR_PARITY;
                end
                FR_PARITY: begin
                    par_n   = dat_s;
                    state_n = FR_STOP;
                end
                FR_STOP: begin
                    state_n = FR_IDLE;
                    if (dat_s && (^shreg ^ par)) begin
                        byte_n = shreg;
                        vld_n  = 1'b1;
                    end else begin
                        err_n  = 1'b1;
                    end
                end
                default: state_n = FR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/z88_ps2_kbd.sv
// rtl/z88_ps2_kbd.sv - PS/2 keyboard to Z88 64-key matrix and flap switch
// Ports: clk 50 MHz, rst (async, active-high), clk_ena 12.5 MHz enable, ps2_clk/ps2_dat pads;
//        kb_matrix (1 = key down, col*8+row), flap_sw (1 = open), scan_code/scan_vld debug,
//        frame_err one-clk strobe on a receive error.
module z88_ps2_kbd
    import z88_kbd_pkg::*;
#(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_ena,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [63:0] kb_matrix,
    output logic        flap_sw,
    output logic [7:0]  scan_code,
    output logic        scan_vld,
    output logic        frame_err
);

    logic [7:0]  rx_byte;
    logic        rx_vld;
    logic        rx_err;

    dec_state_t  dec_state, dec_state_n;
    logic        ext, ext_n, brk, brk_n, flap_n;
    logic [2:0]  skip_cnt, skip_n;
    logic [63:0] matrix_n;
    key_ent_t    ent;

    z88_ps2_rx #(
        .FILT_LEN (FILT_LEN),
        .TIMEOUT  (TIMEOUT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .clk_ena (clk_ena),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .rx_byte (rx_byte),
        .rx_vld  (rx_vld),
        .rx_err  (rx_err)
    );

    assign scan_code = rx_byte;
    assign scan_vld  = rx_vld;
    assign frame_err = rx_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_state <= DEC_KEY;
            ext       <= 1'b0;
            brk       <= 1'b0;
            skip_cnt  <= '0;
            kb_matrix <= '0;
            flap_sw   <= 1'b0;
        end else begin
            dec_state <= dec_state_n;
            ext       <= ext_n;
            brk       <= brk_n;
            skip_cnt  <= skip_n;
            kb_matrix <= matrix_n;
            flap_sw   <= flap_n;
        end
    end

    always_comb begin
        dec_state_n = dec_state;
        ext_n       = ext;
        brk_n       = brk;
        skip_n      = skip_cnt;
        matrix_n    = kb_matrix;
        flap_n      = flap_sw;
        ent         = key_lookup({ext, rx_byte});

        if (rx_vld) begin
            if (dec_state == DEC_SKIP) begin
                // Pause tail bytes: consumed without touching flags or matrix.
                skip_n = skip_cnt - 3'd1;
                if (skip_cnt == 3'd1)
                    dec_state_n = DEC_KEY;
            end else begin
                case (rx_byte)
                    PS2_EXT: ext_n = 1'b1;
                    PS2_BRK: brk_n = 1'b1;
                    PS2_PAUSE: begin
                        skip_n      = PAUSE_SKIP;
                        dec_state_n = DEC_SKIP;
                    end
                    PS2_BAT_OK, PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_ERR0, PS2_ERR1: begin
                        ext_n = 1'b0;
                        brk_n = 1'b0;
                    end
                    default: begin
                        // Plain F12 is the flap switch: each make toggles it.
                        if (rx_byte == PS2_F12 && !ext) begin
                            if (!brk)
                                flap_n = ~flap_sw;
                        end else if (ent.valid) begin
                            matrix_n[ent.idx] = ~brk;
                        end
                        ext_n = 1'b0;
                        brk_n = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_z88_ps2_kbd.sv
// tb/tb_z88_ps2_kbd.sv - directed self-checking bench for z88_ps2_kbd
module tb_z88_ps2_kbd;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_ena;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [63:0] kb_matrix;
    logic        flap_sw;
    logic [7:0]  scan_code;
    logic        scan_vld;
    logic        frame_err;

    z88_ps2_kbd dut (
        .clk       (clk),
        .rst       (rst),
        .clk_ena   (clk_ena),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .kb_matrix (kb_matrix),
        .flap_sw   (flap_sw),
        .scan_code (scan_code),
        .scan_vld  (scan_vld),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    int ena_div = 4;
    int ena_cnt = 0;
    initial begin
        clk_ena = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ena_cnt = (ena_cnt + 1 >= ena_div) ? 0 : ena_cnt + 1;
            clk_ena = (ena_cnt == 0);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: what the DUT showed on the scan_vld clk and on the clk after it.
    logic [7:0]  q_code[$];
    logic [63:0] q_before[$];
    logic [63:0] q_after[$];
    logic        q_flap[$];
    bit          pend = 1'b0;
    int          err_seen = 0;

    always @(negedge clk) begin
        if (pend) begin
            q_after.push_back(kb_matrix);
            q_flap.push_back(flap_sw);
        end
        pend = scan_vld;
        if (scan_vld) begin
            q_code.push_back(scan_code);
            q_before.push_back(kb_matrix);
        end
        if (frame_err)
            err_seen++;
    end

    logic [63:0] cur_mat  = '0;
    logic        cur_flap = 1'b0;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_clk(24);
        ps2_clk = 1'b0;
        wait_clk(48);
        ps2_clk = 1'b1;
        wait_clk(24);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int glitch_at);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == glitch_at) begin
                ps2_clk = 1'b0;
                wait_clk(12);
                ps2_clk = 1'b1;
                wait_clk(48);
            end
            ps2_bit(bits[i]);
        end
    endtask

    task automatic flush_q();
        q_code.delete();
        q_before.delete();
        q_after.delete();
        q_flap.delete();
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] code,
                               input logic [63:0] mat, input logic flap);
        check_eq({tag, "_cnt"}, 64'(q_code.size()), 64'd1);
        if (q_code.size() > 0 && q_after.size() > 0) begin
            check_eq({tag, "_code"}, 64'(q_code.pop_front()), 64'(code));
            check_eq({tag, "_pre"}, q_before.pop_front(), cur_mat);
            check_eq({tag, "_mat"}, q_after.pop_front(), mat);
            check_eq({tag, "_flap"}, 64'(q_flap.pop_front()), 64'(flap));
        end
        flush_q();
        cur_mat  = mat;
        cur_flap = flap;
    endtask

    task automatic send_expect(input string tag, input logic [7:0] code,
                               input logic [63:0] mat, input logic flap);
        send_frame(code, 1'b0, -1);
        expect_byte(tag, code, mat, flap);
    endtask

    task automatic expect_err(input string tag, input int err_base);
        check_eq({tag, "_err"}, 64'(err_seen - err_base), 64'd1);
        check_eq({tag, "_novld"}, 64'(q_code.size()), 64'd0);
        check_eq({tag, "_mat"}, kb_matrix, cur_mat);
        flush_q();
    endtask

    localparam logic [63:0] B6  = 64'd1 << 6;
    localparam logic [63:0] B37 = 64'd1 << 37;
    localparam logic [63:0] B38 = 64'd1 << 38;
    localparam logic [63:0] B49 = 64'd1 << 49;
    localparam logic [63:0] B62 = 64'd1 << 62;

    logic [7:0] pause_seq [8];
    int         err_base;

    initial begin
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        rst     = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_clk(5);
        @(negedge clk);
        check_eq("rst_matrix", kb_matrix, 64'd0);
        check_eq("rst_flap", 64'(flap_sw), 64'd0);
        check_eq("rst_code", 64'(scan_code), 64'd0);
        check_eq("rst_vld", 64'(scan_vld), 64'd0);
        check_eq("rst_err", 64'(frame_err), 64'd0);
        wait_clk(1);
        rst = 1'b0;
        wait_clk(20);

        // A make then break
        send_expect("a_make", 8'h1C, B49, 1'b0);
        send_expect("a_f0", 8'hF0, B49, 1'b0);
        send_expect("a_brk", 8'h1C, 64'd0, 1'b0);

        // Extended up vs keypad 8
        send_expect("up_e0", 8'hE0, 64'd0, 1'b0);
        send_expect("up_make", 8'h75, B38, 1'b0);
        send_expect("kp8", 8'h75, B38, 1'b0);
        send_expect("up_e0b", 8'hE0, B38, 1'b0);
        send_expect("up_f0", 8'hF0, B38, 1'b0);
        send_expect("up_brk", 8'h75, 64'd0, 1'b0);

        // Bad parity, then good left shift
        err_base = err_seen;
        send_frame(8'h1C, 1'b1, -1);
        expect_err("par", err_base);
        send_expect("lsh", 8'h12, B62, 1'b0);

        // Timeout on a partial frame, then space
        err_base = err_seen;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++)
            ps2_bit(1'b1);
        ena_div = 1;
        wait_clk(25200);
        ena_div = 4;
        wait_clk(8);
        expect_err("tmo", err_base);
        send_expect("spc", 8'h29, B62 | B37, 1'b0);

        // Flap toggling via F12
        send_expect("f12_1", 8'h07, B62 | B37, 1'b1);
        send_expect("f12_2", 8'h07, B62 | B37, 1'b0);
        send_expect("f12_f0", 8'hF0, B62 | B37, 1'b0);
        send_expect("f12_brk", 8'h07, B62 | B37, 1'b0);

        // Pause sequence leaves everything alone
        for (int i = 0; i < 8; i++)
            send_expect($sformatf("pause%0d", i), pause_seq[i], B62 | B37, 1'b0);
        send_expect("enter", 8'h5A, B62 | B37 | B6, 1'b0);

        // Glitch mid-frame is filtered out
        send_frame(8'h1C, 1'b0, 5);
        expect_byte("glitch", 8'h1C, B62 | B37 | B6 | B49, 1'b0);

        // Set ext, start a frame, reset mid-frame
        send_expect("rst_e0", 8'hE0, B62 | B37 | B6 | B49, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++)
            ps2_bit(1'b1);
        rst = 1'b1;
        wait_clk(3);
        @(negedge clk);
        check_eq("mrst_matrix", kb_matrix, 64'd0);
        check_eq("mrst_flap", 64'(flap_sw), 64'd0);
        check_eq("mrst_code", 64'(scan_code), 64'd0);
        check_eq("mrst_vld", 64'(scan_vld), 64'd0);
        check_eq("mrst_err", 64'(frame_err), 64'd0);
        wait_clk(1);
        rst = 1'b0;
        flush_q();
        cur_mat  = '0;
        cur_flap = 1'b0;
        wait_clk(20);
        // ext must have been cleared: plain 75 is keypad 8, not up
        send_expect("post_kp8", 8'h75, 64'd0, 1'b0);
        send_expect("post_ent", 8'h5A, B6, 1'b0);

        check_eq("err_total", 64'(err_seen), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
